// File: rtl/train_sequencer_pkg.sv
// Shared constants and types for the training-sample sequencer.
package train_sequencer_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRESENT = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_UPDATE  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] target;
  } sample_t;

endpackage

// File: rtl/train_sequencer_sample_mem.sv
// Dataset storage: DEPTH samples, synchronous write, combinational read.
module train_sequencer_sample_mem
  import train_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  sample_t           wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output sample_t           rdata_o
);

  sample_t mem_q [DEPTH];

  // Contents survive reset so a rerun does not need a reload.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/train_sequencer.sv
// Steps a stored dataset through the network for a programmed number of
// epochs, holding each sample for a settle window and then pulsing update.
module train_sequencer
  import train_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 3,
  parameter int EPOCH_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_a,
  input  logic [DATA_W-1:0]   wr_b,
  input  logic [DATA_W-1:0]   wr_target,
  input  logic [ADDR_W:0]     num_samples,
  input  logic [EPOCH_W-1:0]  num_epochs,
  input  logic [DATA_W-1:0]   step_in,
  input  logic                start,
  input  logic                abort,
  output logic [DATA_W-1:0]   a,
  output logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   target,
  output logic [DATA_W-1:0]   step,
  output logic                update,
  output logic [ADDR_W-1:0]   sample_idx,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   NS_MAX    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   NS_ONE    = (ADDR_W+1)'(1);
  localparam logic [EPOCH_W:0]  EP_ONE    = (EPOCH_W+1)'(1);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     ns_q, ns_d, ns_clamp;
  logic [EPOCH_W-1:0]  ne_q, ne_d;
  logic [ADDR_W-1:0]   sidx_q, sidx_d;
  logic [EPOCH_W-1:0]  ep_q, ep_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, t_q, t_d, step_q, step_d;
  logic                upd_q, upd_d, busy_q, busy_d, done_q, done_d;
  sample_t             wdata, rdata;

  assign wdata = '{a: wr_a, b: wr_b, target: wr_target};

  train_sequencer_sample_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en && (state_q == S_IDLE)),
    .waddr_i (wr_addr),
    .wdata_i (wdata),
    .raddr_i (sidx_q),
    .rdata_o (rdata)
  );

  assign ns_clamp = (num_samples > NS_MAX) ? NS_MAX : num_samples;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ns_d    = ns_q;
    ne_d    = ne_q;
    sidx_d  = sidx_q;
    ep_d    = ep_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ns_d   = ns_clamp;
          ne_d   = num_epochs;
          step_d = step_in;
          if (ns_clamp == '0 || num_epochs == '0) begin
            state_d = S_DONE;
          end else begin
            sidx_d  = '0;
            ep_d    = '0;
            state_d = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        a_d     = rdata.a;
        b_d     = rdata.b;
        t_d     = rdata.target;
        cnt_d   = '0;
        state_d = (LATENCY == 0) ? S_UPDATE : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = S_UPDATE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_UPDATE: begin
        if (({1'b0, sidx_q} + NS_ONE) < ns_q) begin
          sidx_d  = sidx_q + 1'b1;
          state_d = S_PRESENT;
        end else if (({1'b0, ep_q} + EP_ONE) < {1'b0, ne_q}) begin
          sidx_d  = '0;
          ep_d    = ep_q + 1'b1;
          state_d = S_PRESENT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort freezes indices and data outputs where they are.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sidx_d  = sidx_q;
      ep_d    = ep_q;
      a_d     = a_q;
      b_d     = b_q;
      t_d     = t_q;
    end

    upd_d  = (state_d == S_UPDATE);
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_PRESENT) || (state_d == S_SETTLE) || (state_d == S_UPDATE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ns_q    <= '0;
      ne_q    <= '0;
      sidx_q  <= '0;
      ep_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      step_q  <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ne_q    <= ne_d;
      sidx_q  <= sidx_d;
      ep_q    <= ep_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      step_q  <= step_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign target     = t_q;
  assign step       = step_q;
  assign update     = upd_q;
  assign sample_idx = sidx_q;
  assign epoch      = ep_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Training-sample sequencer directly upstream of the input layer and the back-propagating output/hidden layers.
- Holds a small dataset of (a, b, target) 32-bit words, loaded through a write port.
- Presents each sample to the network and waits a fixed settle time for the forward pass. It then pulses update so the layers commit new weights.
- Iterates over all samples for a programmed number of epochs, then reports done.
- Data words are opaque: the block never does arithmetic on them.

Parameters:
- DEPTH, 16, maximum number of stored samples.
- ADDR_W, 4, sample address width; DEPTH <= 2**ADDR_W.
- LATENCY, 3, clk cycles from sample presentation until the network output and deltas are valid.
- EPOCH_W, 16, width of the epoch count and epoch counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous active-high reset.
- wr_en  in  1  dataset write strobe; honoured only in IDLE.
- wr_addr  in  ADDR_W  dataset write address.
- wr_a  in  32  sample input 1.
- wr_b  in  32  sample input 2.
- wr_target  in  32  sample target.
- num_samples  in  ADDR_W+1  samples per epoch; captured at start.
- num_epochs  in  EPOCH_W  epochs to run; captured at start.
- step_in  in  32  learning rate; captured at start.
- start  in  1  begin training; honoured only in IDLE.
- abort  in  1  stop training; return to IDLE without done.
- a  out  32  network input 1 (to the input layer a).
- b  out  32  network input 2 (to the input layer b).
- target  out  32  target word for the output-layer backprop.
- step  out  32  learning rate held for the whole run.
- update  out  1  one-cycle weight-commit pulse to all backprop layers.
- sample_idx  out  ADDR_W  index of the sample currently presented.
- epoch  out  EPOCH_W  current epoch, 0-based.
- busy  out  1  high from the cycle after start until done or abort.
- done  out  1  one-cycle pulse when all epochs have completed.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - a, b, target, step = 0.
  - update, busy, done = 0.
  - sample_idx, epoch = 0.
  - Dataset contents are not reset.
- Any outputs are registered; dataset read is combinational from the array into the output registers.
- States: IDLE, PRESENT, SETTLE, UPDATE, DONE.
- IDLE:
  - wr_en writes mem[wr_addr] = {wr_a, wr_b, wr_target}.
  - start captures num_samples, num_epochs and step_in.
  - If either captured count is 0, go to DONE; otherwise go to PRESENT with sample_idx = 0 and epoch = 0.
  - If wr_en and start coincide, the write happens and start is also accepted.
- PRESENT (1 cycle): load a, b, target from mem[sample_idx]; clear the settle counter; go to SETTLE.
- SETTLE:
  - Count LATENCY cycles with the outputs held stable.
  - On the last count go to UPDATE.
  - LATENCY = 0 goes to UPDATE directly.
- UPDATE (1 cycle): update = 1 and the data outputs are still held. Next state:
  - sample_idx < num_samples-1: increment sample_idx, go to PRESENT.
  - Else, epoch < num_epochs-1: sample_idx = 0, increment epoch, go to PRESENT.
  - Else: go to DONE.
- DONE (1 cycle): done = 1 and busy = 0; go to IDLE. sample_idx and epoch keep their final values.
- Per-sample period is LATENCY+2 cycles. Total cycles from start to the done pulse = num_epochs*num_samples*(LATENCY+2) + 1.
- busy is high in PRESENT, SETTLE and UPDATE.
- abort (any non-IDLE state):
  - Next state is IDLE; update is forced to 0 in that same cycle.
  - done is not pulsed; busy drops.
  - a, b, target and step hold their last values.
  - abort has priority over all transitions; in IDLE it is ignored.
- Ignored inputs:
  - start while not IDLE.
  - wr_en while not IDLE (the dataset is stable during a run).
- num_samples > DEPTH is clamped to DEPTH at capture.
- Counters never wrap: the epoch compare uses the captured num_epochs.
- Reset mid-run: immediate return to the reset values; the dataset is retained.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=0, PRESENT=1, SETTLE=2, UPDATE=3, DONE=4).
  - Data width constant 32.
- One natural sub-module, sample_mem: DEPTH x 96-bit register array with a write port and an async read port.
- Sequencer FSM and counters live in train_sequencer.

Test Plan:
- Load 2 samples {a=1,b=2,t=3}, {a=4,b=5,t=6}; start with num_samples=2, num_epochs=1, step_in=0x10, LATENCY=3:
  - a,b,target = 1,2,3 for 5 cycles, then 4,5,6 for 5 cycles.
  - update pulses at cycles 5 and 10 after start; done at cycle 11.
  - step = 0x10 throughout.
- num_samples=3, num_epochs=2: epoch goes 0 then 1; sample_idx wraps 2 to 0 at the epoch boundary; update pulses 6 times; done after 31 cycles.
- num_epochs=0 (or num_samples=0) with start: done pulses the next cycle, busy never rises, update never pulses.
- Assert abort during SETTLE of sample 1: next cycle state is IDLE, busy=0, no update, no done. A new start then restarts at sample_idx=0, epoch=0.
- Assert wr_en at addr 0 with a=0xFF during a run: the dataset is unchanged, and the second epoch still presents the original a.
- Assert reset during UPDATE: update, busy and outputs go to 0 immediately (asynchronously). After release, rerunning without reloading presents the original dataset words.
